btn_event_gen: RTL and testbench

- Parametrised, multi-channel successor to the single-button slow-clock edge detector.
- Per-channel flow: N raw push-button inputs → synchroniser → tick-qualified debounce → selectable edge detection → optional hold-to-auto-repeat.
- Outputs are one-clock event pulses in the `clk` domain, consumed by the game FSMs (paddle move, start/pause).
- A `tick` enable replaces the separate 2 Hz clock, so all logic runs on one clock.

---
 rtl/btn_event_gen.sv | 70 +++++++
 tb/tb_btn_event_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/btn_event_gen.sv
// btn_event_gen: multi-channel button synchroniser, tick-qualified debouncer, edge detector and auto-repeat.
module btn_event_gen #(
  parameter int N_BTN        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEB_TICKS    = 4,
  parameter int EDGE_MODE    = 0,
  parameter int REPEAT_EN    = 1,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_repeat
);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_TOP    = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - REPEAT_TICKS);

  if (N_BTN < 1 || SYNC_STAGES < 2 || DEB_TICKS < 1 || EDGE_MODE < 0 || EDGE_MODE > 2 ||
      REPEAT_EN < 0 || REPEAT_EN > 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1 ||
      REPEAT_TICKS > HOLD_TICKS) begin : g_bad_param
    $error("btn_event_gen: illegal parameter value");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          deb_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [HW-1:0]          hold_nxt;
    logic                   level_q, pulse_q, repeat_q;
    logic                   s, accept, rise, fall, edge_hit, rep_hit;
    always_comb begin
      s        = sync_q[SYNC_STAGES-1];
      accept   = tick && (s != level_q) && (deb_cnt == DEB_LAST);
      rise     = accept && s;
      fall     = accept && !s;
      edge_hit = (EDGE_MODE == 0) ? rise : (EDGE_MODE == 1) ? fall : accept;
      hold_nxt = hold_cnt + 1'b1;
      // a release cycle never repeats, even if the hold count would expire on it
      rep_hit  = (REPEAT_EN != 0) && tick && level_q && !fall && (hold_nxt == HOLD_TOP);
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q   <= '0;
        deb_cnt  <= '0;
        hold_cnt <= '0;
        level_q  <= 1'b0;
        pulse_q  <= 1'b0;
        repeat_q <= 1'b0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
        deb_cnt  <= (s == level_q || accept) ? '0 : tick ? deb_cnt + 1'b1 : deb_cnt;
        level_q  <= accept ? s : level_q;
        pulse_q  <= edge_hit | rep_hit;
        repeat_q <= rep_hit;
        hold_cnt <= (REPEAT_EN == 0 || accept || !level_q) ? '0 :
                    rep_hit ? HOLD_RELOAD : tick ? hold_nxt : hold_cnt;
      end
    end
    assign btn_level[i]  = level_q;
    assign btn_pulse[i]  = pulse_q;
    assign btn_repeat[i] = repeat_q;
  end
endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: directed plus random stimulus on three configurations against a tick-count reference model.
module tb_btn_event_gen;
  localparam int DEB = 4, HOLD = 8, RPT = 2;
  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b1;
  logic [3:0] btn_in = 4'b0;
  logic [3:0] lvl [3];
  logic [3:0] pls [3];
  logic [3:0] rep [3];
  int checks = 0, passes = 0;
  int emode [3] = '{0, 1, 2};
  bit ren [3] = '{1'b1, 1'b0, 1'b0};
  logic [3:0] p0 [3], p1 [3], m_lvl [3], m_pls [3], m_rep [3];
  int run [3][4], held [3][4], pcnt [3][4], rcnt [3][4];
  int rc0;

  always #5 clk = ~clk;

  btn_event_gen u0 (.clk(clk), .rst_n(rst_n), .tick(tick), .btn_in(btn_in),
                    .btn_level(lvl[0]), .btn_pulse(pls[0]), .btn_repeat(rep[0]));
  btn_event_gen #(.EDGE_MODE(1), .REPEAT_EN(0)) u1 (.clk(clk), .rst_n(rst_n), .tick(tick), .btn_in(btn_in),
                    .btn_level(lvl[1]), .btn_pulse(pls[1]), .btn_repeat(rep[1]));
  btn_event_gen #(.EDGE_MODE(2), .REPEAT_EN(0)) u2 (.clk(clk), .rst_n(rst_n), .tick(tick), .btn_in(btn_in),
                    .btn_level(lvl[2]), .btn_pulse(pls[2]), .btn_repeat(rep[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      p0[k] = '0; p1[k] = '0; m_lvl[k] = '0; m_pls[k] = '0; m_rep[k] = '0;
      for (int c = 0; c < 4; c++) begin
        run[k][c] = 0;
        held[k][c] = 0;
      end
    end
  endtask

  // Level accepted after DEB qualifying mismatch ticks; repeats when ticks-since-press
  // reaches HOLD and every RPT ticks after that.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        bit s, acc, rp;
        s = p1[k][c];
        p1[k][c] = p0[k][c];
        p0[k][c] = btn_in[c];
        acc = 1'b0;
        if (s == m_lvl[k][c]) run[k][c] = 0;
        else if (tick) begin
          run[k][c]++;
          if (run[k][c] == DEB) begin
            acc = 1'b1;
            run[k][c] = 0;
          end
        end
        rp = 1'b0;
        if (acc) held[k][c] = 0;
        else if (ren[k] && tick && m_lvl[k][c]) begin
          held[k][c]++;
          rp = (held[k][c] >= HOLD) && ((held[k][c] - HOLD) % RPT == 0);
        end
        m_rep[k][c] = rp;
        m_pls[k][c] = rp | (acc && (emode[k] == 2 || ((emode[k] == 0) == s)));
        if (acc) m_lvl[k][c] = s;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("level%0d", k), lvl[k], m_lvl[k]);
      chk($sformatf("pulse%0d", k), pls[k], m_pls[k]);
      chk($sformatf("repeat%0d", k), rep[k], m_rep[k]);
      for (int c = 0; c < 4; c++) begin
        pcnt[k][c] += int'(pls[k][c]);
        rcnt[k][c] += int'(rep[k][c]);
      end
    end
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        pcnt[k][c] = 0;
        rcnt[k][c] = 0;
      end
    btn_in = 4'b0001;
    repeat (3) step();
    chk("rst_level", lvl[0], 4'b0);
    chk("rst_pulse", pls[0], 4'b0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("lat_level_early", lvl[0], 4'b0);
    step();
    chk("lat_level", lvl[0], 4'b0001);
    chk("lat_pulse", pls[0], 4'b0001);
    chk("lat_repeat", rep[0], 4'b0);
    chk("lat_pulse_mode1", pls[1], 4'b0);
    chk("lat_pulse_mode2", pls[2], 4'b0001);
    step();
    chk("lat_drop", pls[0], 4'b0);

    btn_in[1] = 1'b1;
    repeat (3) step();
    btn_in[1] = 1'b0;
    repeat (10) step();
    chk("glitch_level", lvl[0][1], 1'b0);
    chk("glitch_pulses", pcnt[0][1], 0);
    btn_in[1] = 1'b1;
    repeat (4) step();
    btn_in[1] = 1'b0;
    repeat (2) step();
    chk("pulse4_level", lvl[0][1], 1'b1);
    chk("pulse4_pulse", pls[0][1], 1'b1);
    repeat (12) step();
    chk("pulse4_count", pcnt[0][1], 1);

    btn_in[2] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick = (i % 10 == 9);
      step();
      if (i == 38) chk("tick_level_before", lvl[0][2], 1'b0);
      if (i == 39) chk("tick_level_at4", lvl[0][2], 1'b1);
    end
    tick = 1'b1;

    btn_in[3] = 1'b1;
    repeat (6) step();
    chk("hold_press_pulse", pls[0][3], 1'b1);
    chk("hold_press_repeat", rep[0][3], 1'b0);
    rc0 = rcnt[0][3];
    repeat (19) step();
    chk("hold_repeat_count", rcnt[0][3] - rc0, 6);
    btn_in[3] = 1'b0;
    repeat (6) step();
    chk("release_level", lvl[0][3], 1'b0);
    rc0 = rcnt[0][3];
    repeat (20) step();
    chk("release_no_repeat", rcnt[0][3] - rc0, 0);

    btn_in[0] = 1'b0;
    repeat (10) step();
    chk("mode1_pulses", pcnt[1][0], 1);
    chk("mode2_pulses", pcnt[2][0], 2);

    btn_in[3] = 1'b1;
    repeat (15) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_level", lvl[0], 4'b0);
    chk("async_pulse", pls[0] | pls[2], 4'b0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("rerst_press", pls[0], 4'b1100);
    chk("rerst_press_rep", rep[0], 4'b0);
    repeat (8) step();
    chk("rerst_first_repeat", rep[0], 4'b1100);

    for (int i = 0; i < 400; i++) begin
      if ($urandom % 6 == 0) btn_in[$urandom % 4] = ~btn_in[$urandom % 4];
      tick = ($urandom % 4) != 0;
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
